nn_dataset_writer: RTL and testbench

Write-side front end for the neural processor's 2048×32 data memory. Accepts a framed word stream: header, then training records, then test records. Writes each word into the memory through a write port, then sequences the processor. It pulses `train`, waits for the processor's ready-to-test sentinel, then pulses `test` once per test record and returns each network output on a result port.

---
 rtl/nn_dataset_writer_if.sv | 44 ++++
 rtl/nn_dataset_writer.sv | 186 ++++++++++++++++++
 tb/tb_nn_dataset_writer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_dataset_writer_if.sv
// nn_dataset_writer_if
//   Bundles the signals between the dataset writer and its neighbours. These are
//   the framed input stream, the data-memory write port, the processor
//   train/test handshake, the result port and the status flags. Signal names
//   match the writer's original flat ports.
//
//   Modports:
//     master : stream source / processor / memory side (drives s_valid, s_data,
//              s_last, test_output; observes everything else)
//     slave  : the writer itself (nn_dataset_writer)
//
//   Parameter:
//     ADDR_W : data-memory address width
`timescale 1ns/1ps
interface nn_dataset_writer_if #(
    parameter int ADDR_W = 11
);
    logic              s_valid;
    logic [31:0]       s_data;
    logic              s_last;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              train;
    logic              test;
    logic [31:0]       test_output;
    logic              result_valid;
    logic [31:0]       result_data;
    logic              busy;
    logic              error;

    modport master (
        output s_valid, s_data, s_last, test_output,
        input  s_ready, mem_we, mem_waddr, mem_wdata, train, test,
               result_valid, result_data, busy, error
    );

    modport slave (
        input  s_valid, s_data, s_last, test_output,
        output s_ready, mem_we, mem_waddr, mem_wdata, train, test,
               result_valid, result_data, busy, error
    );
endinterface

// File: rtl/nn_dataset_writer.sv
// nn_dataset_writer
//   Write-side front end for the neural processor's data memory. It takes a
//   framed stream made of a numTrain word, a numTest word, then
//   (numTrain+numTest)*REC_WORDS record words. Each accepted word is written to
//   memory one cycle later, at consecutive addresses from 0. After the last
//   record word the block pulses train, waits for the processor's
//   ready-to-test sentinel, then issues one test pulse per test record. Each
//   sampled network output is returned on result_data/result_valid.
//
//   Ports:
//     clk, rst : clock; asynchronous active-high reset
//     bus      : nn_dataset_writer_if.slave
//                (stream in, memory write port, train/test, result, busy/error)
//
//   Parameters: ADDR_W (memory address width), REC_WORDS (words per record),
//               TEST_WAIT (cycles from test pulse to sampling test_output)
//
//   Build option: define NN_WRITER_WDOG_EN to add a 24-bit watchdog on the
//   wait for the train-complete sentinel. The watchdog sends the block to ERR
//   after 2^24-1 cycles without the sentinel.
`timescale 1ns/1ps
module nn_dataset_writer #(
    parameter int ADDR_W    = 11,
    parameter int REC_WORDS = 5,
    parameter int TEST_WAIT = 12
) (
    input logic              clk,
    input logic              rst,
    nn_dataset_writer_if.slave bus
);
    localparam logic [31:0] SENTINEL  = 32'hD00D_B00B;
    localparam int unsigned MEM_WORDS = 1 << ADDR_W;
    localparam int          WAIT_W    = (TEST_WAIT > 0) ? $clog2(TEST_WAIT + 1) : 1;

    typedef enum logic [3:0] {
        IDLE, HDR_TEST, BODY, KICK_TRAIN, WAIT_TRAIN,
        KICK_TEST, WAIT_TEST, DONE, ERR
    } state_t;

    state_t            state;
    logic [7:0]        num_train;
    logic [7:0]        rem_test;
    logic [11:0]       body_len;
    logic [11:0]       word_cnt;
    logic [WAIT_W-1:0] wait_cnt;
`ifdef NN_WRITER_WDOG_EN
    localparam logic [23:0] WDOG_LIMIT = 24'hFF_FFFE;
    logic [23:0]       wdog;
`endif

    logic        accept;
    logic [11:0] hdr_len;
    logic        hdr_overflow;

    assign accept = bus.s_valid & bus.s_ready;

    // Body length is formed while the numTest word is on the bus, so that the
    // overflow decision can suppress that same word's write.
    assign hdr_len      = 12'((32'(num_train) + 32'(bus.s_data[7:0])) * 32'(REC_WORDS));
    assign hdr_overflow = (32'(hdr_len) + 32'd2) > 32'(MEM_WORDS);

    // Moore decodes of the state register.
    assign bus.s_ready = (state == IDLE) || (state == HDR_TEST) || (state == BODY);
    assign bus.busy    = !((state == IDLE) || (state == ERR) || (state == DONE));
    assign bus.error   = (state == ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            num_train        <= '0;
            rem_test         <= '0;
            body_len         <= '0;
            word_cnt         <= '0;
            wait_cnt         <= '0;
            bus.mem_we       <= 1'b0;
            bus.mem_waddr    <= '0;
            bus.mem_wdata    <= '0;
            bus.train        <= 1'b0;
            bus.test         <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.result_data  <= '0;
`ifdef NN_WRITER_WDOG_EN
            wdog             <= '0;
`endif
        end else begin
            bus.mem_we       <= 1'b0;
            bus.train        <= 1'b0;
            bus.test         <= 1'b0;
            bus.result_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        num_train     <= bus.s_data[7:0];
                        bus.mem_we    <= 1'b1;
                        bus.mem_waddr <= '0;
                        bus.mem_wdata <= bus.s_data;
                        state         <= bus.s_last ? ERR : HDR_TEST;
                    end
                end

                HDR_TEST: begin
                    if (accept) begin
                        if (hdr_overflow) begin
                            state <= ERR;
                        end else begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_waddr <= ADDR_W'(1);
                            bus.mem_wdata <= bus.s_data;
                            rem_test      <= bus.s_data[7:0];
                            body_len      <= hdr_len;
                            word_cnt      <= '0;
                            if (hdr_len == '0)
                                state <= DONE;
                            else if (bus.s_last)
                                state <= ERR;
                            else
                                state <= BODY;
                        end
                    end
                end

                BODY: begin
                    if (accept) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_waddr <= ADDR_W'(32'(word_cnt) + 32'd2);
                        bus.mem_wdata <= bus.s_data;
                        if (word_cnt == body_len - 12'd1) begin
                            // train is raised on entry to KICK_TRAIN so that it
                            // lines up with the final word's memory write.
                            bus.train <= (num_train != '0);
                            state     <= KICK_TRAIN;
                        end else begin
                            word_cnt <= word_cnt + 12'd1;
                            if (bus.s_last)
                                state <= ERR;
                        end
                    end
                end

                KICK_TRAIN: begin
`ifdef NN_WRITER_WDOG_EN
                    wdog <= '0;
`endif
                    state <= (num_train == '0) ? KICK_TEST : WAIT_TRAIN;
                end

                WAIT_TRAIN: begin
                    if (bus.test_output == SENTINEL)
                        state <= KICK_TEST;
`ifdef NN_WRITER_WDOG_EN
                    else if (wdog == WDOG_LIMIT)
                        state <= ERR;
                    else
                        wdog <= wdog + 24'd1;
`endif
                end

                KICK_TEST: begin
                    if (rem_test == '0) begin
                        state <= DONE;
                    end else begin
                        bus.test <= 1'b1;
                        wait_cnt <= WAIT_W'(TEST_WAIT);
                        state    <= WAIT_TEST;
                    end
                end

                WAIT_TEST: begin
                    if (wait_cnt == '0) begin
                        bus.result_data  <= bus.test_output;
                        bus.result_valid <= 1'b1;
                        rem_test         <= rem_test - 8'd1;
                        state            <= KICK_TEST;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                DONE:    state <= IDLE;
                ERR:     state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nn_dataset_writer.sv
// tb_nn_dataset_writer
//   Scoreboard bench for nn_dataset_writer. The stimulus side derives the
//   expected memory writes from the stream layout: stream position i lands at
//   address i, up to the first error point. It also derives the expected
//   train/test pulse counts. A processor model answers train with the sentinel
//   and each test pulse with a random output, which it queues as the expected
//   result. A monitor pops and compares on every mem_we / result_valid and also
//   checks pulse timing.
`timescale 1ns/1ps
module tb_nn_dataset_writer;
    localparam int ADDR_W    = 11;
    localparam int REC_WORDS = 5;
    localparam int TEST_WAIT = 12;
    localparam logic [31:0] SENTINEL = 32'hD00D_B00B;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nn_dataset_writer_if #(.ADDR_W(ADDR_W)) bus ();

    nn_dataset_writer #(
        .ADDR_W(ADDR_W), .REC_WORDS(REC_WORDS), .TEST_WAIT(TEST_WAIT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_res[$];
    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int n_train = 0, n_test = 0, exp_train = 0, exp_test = 0;
    int last_test = -1;
    bit proc_en = 1'b1;
    int sent_cnt = -1;
    logic [31:0] pv;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every write and result against the scoreboard.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (!bus.busy) last_test = -1;
                if (bus.mem_we) begin
                    if (exp_wr.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_write: addr %h data %h, no write required", bus.mem_waddr, bus.mem_wdata);
                    end else begin
                        w = exp_wr.pop_front();
                        check("write_addr", 32'(bus.mem_waddr), 32'(w.a));
                        check("write_data", bus.mem_wdata, w.d);
                    end
                end
                if (bus.train) begin
                    n_train++;
                    check("train_with_final_write", 32'(bus.mem_we), 32'd1);
                    last_test = -1;
                end
                if (bus.test) begin
                    n_test++;
                    if (last_test >= 0) check("test_spacing", 32'(cyc - last_test), 32'(TEST_WAIT + 2));
                    last_test = cyc;
                end
                if (bus.result_valid) begin
                    if (exp_res.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_result: data %h, no result required", bus.result_data);
                    end else begin
                        check("result_data", bus.result_data, exp_res.pop_front());
                        check("result_latency", 32'(cyc - last_test), 32'(TEST_WAIT + 1));
                    end
                end
            end
        end
    end

    // Processor model: sentinel a few cycles after train, random output per test.
    initial begin
        bus.test_output = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sent_cnt = -1;
                bus.test_output = '0;
            end else begin
                if (bus.train) begin
                    bus.test_output = $urandom & 32'h7FFF_FFFF;
                    sent_cnt = $urandom_range(1, 5);
                end else if (sent_cnt > 0) begin
                    sent_cnt--;
                end else if (sent_cnt == 0) begin
                    if (proc_en) bus.test_output = SENTINEL;
                    sent_cnt = -1;
                end
                if (bus.test) begin
                    pv = $urandom;
                    if (pv == SENTINEL) pv = pv ^ 32'd1;
                    bus.test_output = pv;
                    exp_res.push_back(pv);
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input bit last, input int gap);
        repeat (gap) begin
            @(negedge clk);
            bus.s_valid = 1'b0;
        end
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        for (int t = 0; !bus.s_ready; t++) begin
            if (t >= 100) begin
                n_cmp++; n_bad++;
                $display("FAIL ready_timeout: s_ready 0 for %0d cycles, required 1", t);
                break;
            end
            @(negedge clk);
        end
    endtask

    // Reference model plus driver. Stream position i is written to address i
    // until the first error point; outcome 0 = complete, 1 = error, 2 = cut short.
    task automatic do_stream(input logic [31:0] h0, input logic [31:0] h1,
                             input logic [31:0] body[$], input int last_idx,
                             input int n_send, input int gapmode, output int outcome);
        int nt, ns, len, n_acc, gap;
        logic [31:0] w;
        nt = int'(h0[7:0]);
        ns = int'(h1[7:0]);
        len = (nt + ns) * REC_WORDS;
        outcome = 2;
        n_acc = n_send;
        for (int i = 0; i < n_send; i++) begin
            w = (i == 0) ? h0 : (i == 1) ? h1 : body[i-2];
            if (i == 1 && 2 + len > (1 << ADDR_W)) begin
                outcome = 1; n_acc = i + 1; break;
            end
            exp_wr.push_back({ADDR_W'(i), w});
            if (i >= 1 && i - 2 == len - 1) begin
                outcome = 0; n_acc = i + 1; break;
            end
            if (i == last_idx) begin
                outcome = 1; n_acc = i + 1; break;
            end
        end
        if (outcome == 0) begin
            if (nt > 0) exp_train++;
            exp_test += ns;
        end
        for (int i = 0; i < n_acc; i++) begin
            w = (i == 0) ? h0 : (i == 1) ? h1 : body[i-2];
            gap = (i < 2) ? 0 : (gapmode == 1) ? 1 : (gapmode == 2) ? $urandom_range(0, 2) : 0;
            send_word(w, i == last_idx, gap);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic finish_ok(input string tag);
        int t;
        t = 0;
        while (bus.busy && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        check({tag, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
        check({tag, "_results_left"}, 32'(exp_res.size()), 32'd0);
        check({tag, "_train_count"}, 32'(n_train), 32'(exp_train));
        check({tag, "_test_count"}, 32'(n_test), 32'(exp_test));
        check({tag, "_error"}, 32'(bus.error), 32'd0);
        check({tag, "_ready"}, 32'(bus.s_ready), 32'd1);
    endtask

    task automatic finish_err(input string tag);
        repeat (20) @(negedge clk);
        check({tag, "_error"}, 32'(bus.error), 32'd1);
        check({tag, "_ready"}, 32'(bus.s_ready), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
        check({tag, "_train_count"}, 32'(n_train), 32'(exp_train));
        check({tag, "_test_count"}, 32'(n_test), 32'(exp_test));
        do_reset();
        check({tag, "_error_cleared"}, 32'(bus.error), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] b[$];
        int oc, nt, ns, len, last;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_s_ready", 32'(bus.s_ready), 32'd1);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_waddr", 32'(bus.mem_waddr), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_train", 32'(bus.train), 32'd0);
        check("rst_test", 32'(bus.test), 32'd0);
        check("rst_result_valid", 32'(bus.result_valid), 32'd0);
        check("rst_result_data", bus.result_data, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        rst = 1'b0;

        // Directed: 2 train + 1 test record, body 0x0001_0000..0x000F_0000.
        b.delete();
        for (int k = 1; k <= 15; k++) b.push_back(32'(k) << 16);
        do_stream(32'd2, 32'd1, b, 16, 17, 0, oc);
        finish_ok("basic");

        // Empty dataset.
        b.delete();
        do_stream(32'd0, 32'd0, b, 1, 2, 0, oc);
        finish_ok("empty");

        // Randomized small datasets with random stalls and optional s_last.
        for (int k = 0; k < 8; k++) begin
            nt = $urandom_range(0, 3);
            ns = $urandom_range(0, 3);
            len = (nt + ns) * REC_WORDS;
            b.delete();
            for (int j = 0; j < len; j++) b.push_back($urandom);
            last = ($urandom_range(0, 1) == 1) ? len + 1 : -1;
            do_stream(($urandom & 32'hFFFF_FF00) | 32'(nt), ($urandom & 32'hFFFF_FF00) | 32'(ns),
                      b, last, len + 2, $urandom_range(0, 2), oc);
            finish_ok("rand");
        end

        // s_valid toggling every other cycle through the body.
        b.delete();
        for (int j = 0; j < 10; j++) b.push_back($urandom);
        do_stream(32'd1, 32'd1, b, 11, 12, 1, oc);
        finish_ok("toggle");

        // Largest legal body: 200+200 records = 2000 words.
        b.delete();
        for (int j = 0; j < 2000; j++) b.push_back($urandom);
        do_stream(32'd200, 32'd200, b, 2001, 2002, 0, oc);
        finish_ok("fit2000");

        // 255+200 records overflows memory; numTest word is not written.
        b.delete();
        do_stream(32'hA5A5_A5FF, 32'd200, b, -1, 2, 0, oc);
        finish_err("overflow");

        // s_last on body word 3 of a 10-word body.
        b.delete();
        for (int j = 0; j < 10; j++) b.push_back($urandom);
        do_stream(32'd1, 32'd1, b, 5, 12, 0, oc);
        finish_err("early_last");

        // Reset mid-body, then a fresh stream must restart at address 0.
        b.delete();
        for (int j = 0; j < 10; j++) b.push_back($urandom);
        do_stream(32'd2, 32'd0, b, -1, 6, 0, oc);
        @(negedge clk);
        do_reset();
        check("midrst_writes_left", 32'(exp_wr.size()), 32'd0);
        check("midrst_ready", 32'(bus.s_ready), 32'd1);
        b.delete();
        for (int j = 0; j < 5; j++) b.push_back($urandom);
        do_stream(32'd0, 32'd1, b, 6, 7, 2, oc);
        finish_ok("after_rst");

        // Sentinel never arrives: block must keep waiting.
        proc_en = 1'b0;
        b.delete();
        for (int j = 0; j < 5; j++) b.push_back($urandom);
        do_stream(32'd1, 32'd0, b, 6, 7, 0, oc);
        repeat (300) @(negedge clk);
        check("hang_busy", 32'(bus.busy), 32'd1);
        check("hang_error", 32'(bus.error), 32'd0);
        check("hang_ready", 32'(bus.s_ready), 32'd0);
        check("hang_train_count", 32'(n_train), 32'(exp_train));
        check("hang_writes_left", 32'(exp_wr.size()), 32'd0);
        do_reset();
        proc_en = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
